// File: rtl/rvvi_stream_packer.sv
// Frame FIFO plus serializer that packs RVVI trace frames into OUT_WIDTH beats, LSB first.
// Optional header beat per packet when RVVI_PACKER_SEQ_HDR_EN is defined.
module rvvi_stream_packer #(
    parameter int XLEN              = 64,
    parameter int MAX_CSRS          = 5,
    parameter int OUT_WIDTH         = 64,
    parameter int DEPTH             = 4,
    parameter int FRAME_COUNT_WIDTH = 16,
    localparam int BASE = 72 + 5 * XLEN,
    localparam int SLOT = XLEN + 16,
    localparam int FW   = BASE + MAX_CSRS * SLOT,
    localparam int CW   = $clog2(MAX_CSRS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         InValid,
    input  logic [FW-1:0]                InFrame,
    input  logic [CW-1:0]                InCSRCount,
    output logic                         InReady,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [OUT_WIDTH-1:0]         OutData,
    output logic                         OutLast,
    output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
    output logic [FRAME_COUNT_WIDTH-1:0] DropCount,
    output logic                         Overflow
);
    localparam int NB_MAX = (FW + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int PW     = NB_MAX * OUT_WIDTH;
    localparam int AW     = $clog2(DEPTH);
    localparam int BW     = $clog2(NB_MAX + 1);

`ifdef RVVI_PACKER_SEQ_HDR_EN
    typedef enum logic [1:0] {IDLE, SEND, HDR} state_t;
    localparam state_t FIRST = HDR;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
    localparam state_t FIRST = SEND;
`endif

    function automatic logic [CW-1:0] clamp_n(input logic [CW-1:0] n);
        return (n > CW'(MAX_CSRS)) ? CW'(MAX_CSRS) : n;
    endfunction

    function automatic logic [BW-1:0] beats_for(input logic [CW-1:0] n);
        int len;
        len = BASE + int'(n) * SLOT;
        return BW'((len + OUT_WIDTH - 1) / OUT_WIDTH);
    endfunction

    logic [FW-1:0] frame_mem [DEPTH];
    logic [CW-1:0] n_mem     [DEPTH];
    logic [BW-1:0] b_mem     [DEPTH];
`ifdef RVVI_PACKER_SEQ_HDR_EN
    logic [15:0]   tag_mem   [DEPTH];
`endif

    logic [AW:0]   wr, rd, occupancy;
    logic          full, empty, push, pop, more;
    state_t        state, state_next, cur;
    logic [BW-1:0] beat, beat_next;

    logic [FW-1:0] head_frame;
    logic [CW-1:0] head_n;
    logic [BW-1:0] head_b;
    logic [31:0]   head_len;
    logic [PW-1:0] mask, payload, shifted;

    // Full/empty come from registered pointers only, so a pop never frees a slot for the same cycle.
    assign occupancy = wr - rd;
    assign empty     = (wr == rd);
    assign full      = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign more      = (occupancy != (AW+1)'(1));
    assign InReady   = ~full;
    assign push      = InValid & ~full & ~reset;

    always_ff @(posedge clk) begin
        if (push) begin
            frame_mem[wr[AW-1:0]] <= InFrame;
            n_mem[wr[AW-1:0]]     <= clamp_n(InCSRCount);
            b_mem[wr[AW-1:0]]     <= beats_for(clamp_n(InCSRCount));
`ifdef RVVI_PACKER_SEQ_HDR_EN
            tag_mem[wr[AW-1:0]]   <= 16'(FrameCount);
`endif
        end
    end

    assign head_frame = frame_mem[rd[AW-1:0]];
    assign head_n     = n_mem[rd[AW-1:0]];
    assign head_b     = b_mem[rd[AW-1:0]];
    assign head_len   = 32'(BASE) + 32'(head_n) * 32'(SLOT);
    assign mask       = ~({PW{1'b1}} << head_len);
    assign payload    = PW'(head_frame) & mask;
    assign shifted    = payload >> (int'(beat) * OUT_WIDTH);

    // IDLE with a queued frame behaves as the first active state, giving one-cycle latency.
    always_comb begin
        cur = state;
        if (state == IDLE && !empty) cur = FIRST;
        state_next = cur;
        beat_next  = beat;
        pop        = 1'b0;
        OutValid   = 1'b0;
        OutLast    = 1'b0;
        OutData    = '0;
        case (cur)
`ifdef RVVI_PACKER_SEQ_HDR_EN
            HDR: begin
                OutValid = 1'b1;
                OutData  = OUT_WIDTH'({8'(head_b), 8'(head_n), tag_mem[rd[AW-1:0]]});
                if (OutReady) state_next = SEND;
            end
`endif
            SEND: begin
                OutValid = 1'b1;
                OutData  = shifted[OUT_WIDTH-1:0];
                OutLast  = (beat == head_b - 1'b1);
                if (OutReady) begin
                    if (OutLast) begin
                        pop        = 1'b1;
                        beat_next  = '0;
                        state_next = more ? FIRST : IDLE;
                    end else begin
                        beat_next  = beat + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr         <= '0;
            rd         <= '0;
            state      <= IDLE;
            beat       <= '0;
            FrameCount <= '0;
            DropCount  <= '0;
            Overflow   <= 1'b0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
            if (push) begin
                wr         <= wr + 1'b1;
                FrameCount <= FrameCount + 1'b1;
            end
            if (pop) rd <= rd + 1'b1;
            if (InValid && full) begin
                Overflow <= 1'b1;
                if (~&DropCount) DropCount <= DropCount + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rvvi_stream_packer.sv
// Bench for rvvi_stream_packer: directed and random traffic against a packet-level queue model.
// Honours RVVI_PACKER_SEQ_HDR_EN when the design is built with the header beat.
module tb_rvvi_stream_packer;
    localparam int XLEN      = 64;
    localparam int MAX_CSRS  = 5;
    localparam int OUT_WIDTH = 64;
    localparam int DEPTH     = 4;
    localparam int FCW       = 16;
    localparam int BASE      = 72 + 5 * XLEN;
    localparam int SLOT      = XLEN + 16;
    localparam int FW        = BASE + MAX_CSRS * SLOT;
    localparam int CW        = $clog2(MAX_CSRS + 1);
    localparam int NW        = (FW + 31) / 32;
`ifdef RVVI_PACKER_SEQ_HDR_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 InValid;
    logic [FW-1:0]        InFrame;
    logic [CW-1:0]        InCSRCount;
    logic                 InReady;
    logic                 OutValid;
    logic                 OutReady;
    logic [OUT_WIDTH-1:0] OutData;
    logic                 OutLast;
    logic [FCW-1:0]       FrameCount;
    logic [FCW-1:0]       DropCount;
    logic                 Overflow;

    rvvi_stream_packer #(
        .XLEN(XLEN), .MAX_CSRS(MAX_CSRS), .OUT_WIDTH(OUT_WIDTH),
        .DEPTH(DEPTH), .FRAME_COUNT_WIDTH(FCW)
    ) dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InFrame(InFrame),
        .InCSRCount(InCSRCount), .InReady(InReady), .OutValid(OutValid),
        .OutReady(OutReady), .OutData(OutData), .OutLast(OutLast),
        .FrameCount(FrameCount), .DropCount(DropCount), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_WIDTH-1:0] data;
        bit                   last;
    } beat_t;

    beat_t          expq[$];
    int             lens[$];
    int             cur_len;
    int             occ;
    logic [FCW-1:0] fc, dc;
    bit             ovf;
    int             errors = 0;
    int             checks = 0;
    bit             pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected packet: optional header, then the first L payload bits cut into beats.
    task automatic model_push(input logic [FW-1:0] f, input int nraw);
        int    n, len, nb;
        beat_t b;
        n   = (nraw > MAX_CSRS) ? MAX_CSRS : nraw;
        len = BASE + n * SLOT;
        nb  = (len + OUT_WIDTH - 1) / OUT_WIDTH;
        if (HB == 1) begin
            b.data = OUT_WIDTH'({8'(nb), 8'(n), 16'(fc)});
            b.last = 1'b0;
            expq.push_back(b);
        end
        for (int k = 0; k < nb; k++) begin
            b.data = '0;
            for (int j = 0; j < OUT_WIDTH; j++)
                if (k * OUT_WIDTH + j < len) b.data[j] = f[k * OUT_WIDTH + j];
            b.last = (k == nb - 1);
            expq.push_back(b);
        end
    endtask

    task automatic cycle(input bit rst, input bit v, input int n, input bit rdy);
        logic [NW*32-1:0]     wide;
        logic [FW-1:0]        f;
        bit                   exp_v, acc;
        logic [OUT_WIDTH-1:0] exp_d;
        bit                   exp_l;
        for (int i = 0; i < NW; i++) wide[i*32 +: 32] = $urandom();
        f          = wide[FW-1:0];
        reset      = rst;
        InValid    = v;
        InFrame    = f;
        InCSRCount = CW'(n);
        OutReady   = rdy;
        #1;
        exp_v = (expq.size() > 0);
        exp_d = exp_v ? expq[0].data : '0;
        exp_l = exp_v ? expq[0].last : 1'b0;
        chk("OutValid", 64'(OutValid), 64'(exp_v));
        chk("OutData", 64'(OutData), 64'(exp_d));
        chk("OutLast", 64'(OutLast), 64'(exp_l));
        chk("InReady", 64'(InReady), 64'(occ < DEPTH));
        chk("FrameCount", 64'(FrameCount), 64'(fc));
        chk("DropCount", 64'(DropCount), 64'(dc));
        chk("Overflow", 64'(Overflow), 64'(ovf));
        if (OutValid && rdy) begin
            cur_len++;
            if (OutLast) begin
                lens.push_back(cur_len);
                cur_len = 0;
            end
        end
        if (rst) begin
            expq.delete();
            occ     = 0;
            fc      = '0;
            dc      = '0;
            ovf     = 1'b0;
            cur_len = 0;
        end else begin
            acc = v && (occ < DEPTH);
            if (exp_v && rdy) begin
                if (expq[0].last) occ--;
                void'(expq.pop_front());
            end
            if (acc) begin
                model_push(f, n);
                occ++;
                fc = fc + 1'b1;
            end else if (v) begin
                if (dc != '1) dc = dc + 1'b1;
                ovf = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles, input bit rdy);
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, 0, rdy);
    endtask

    initial begin
        reset      = 1'b1;
        InValid    = 1'b1;
        InFrame    = '0;
        InCSRCount = '0;
        OutReady   = 1'b1;
        occ = 0; fc = '0; dc = '0; ovf = 1'b0; cur_len = 0;
        repeat (3) @(negedge clk);

        // Frames offered during reset were not taken; then a 7-beat packet with n=0.
        cycle(1'b1, 1'b1, 0, 1'b1);
        idle(2, 1'b1);
        lens.delete();
        cycle(1'b0, 1'b1, 0, 1'b1);
        idle(10, 1'b1);
        chk("pkts_n0", 64'(lens.size()), 64'(1));
        if (lens.size() > 0) chk("len_n0", 64'(lens[0]), 64'(7 + HB));

        // n=2 then n=5 back-to-back.
        cycle(1'b1, 1'b0, 0, 1'b1);
        lens.delete();
        cycle(1'b0, 1'b1, 2, 1'b1);
        cycle(1'b0, 1'b1, 5, 1'b1);
        idle(26, 1'b1);
        chk("fc_two", 64'(FrameCount), 64'(2));
        chk("pkts_2_5", 64'(lens.size()), 64'(2));
        if (lens.size() == 2) begin
            chk("len_n2", 64'(lens[0]), 64'(9 + HB));
            chk("len_n5", 64'(lens[1]), 64'(13 + HB));
        end

        // Six offers with the sink stalled: four accepted, two dropped.
        cycle(1'b1, 1'b0, 0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, $urandom_range(0, 7), 1'b0);
        chk("full_inready", 64'(InReady), 64'(0));
        chk("full_drops", 64'(DropCount), 64'(2));
        chk("full_ovf", 64'(Overflow), 64'(1));
        chk("full_fc", 64'(FrameCount), 64'(4));
        idle(70, 1'b1);

        // Sink toggling 1,0,0,1 through an n=2 packet.
        lens.delete();
        cycle(1'b0, 1'b1, 2, 1'b1);
        for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, 0, pat[i % 4]);
        chk("len_stall", 64'(lens.size() > 0 ? lens[0] : 0), 64'(9 + HB));

        // Reset while beat 3 of a 9-beat packet is on the bus.
        cycle(1'b0, 1'b1, 2, 1'b1);
        idle(3 + HB, 1'b1);
        cycle(1'b1, 1'b0, 0, 1'b1);
        chk("rst_valid", 64'(OutValid), 64'(0));
        chk("rst_inready", 64'(InReady), 64'(1));
        chk("rst_fc", 64'(FrameCount), 64'(0));
        lens.delete();
        cycle(1'b0, 1'b1, 1, 1'b1);
        idle(12, 1'b1);
        chk("len_after_rst", 64'(lens.size() > 0 ? lens[0] : 0), 64'(8 + HB));

        // Random traffic, CSR counts including out-of-range values.
        for (int i = 0; i < 500; i++)
            cycle(1'b0, ($urandom_range(0, 9) < 4), $urandom_range(0, 7),
                  ($urandom_range(0, 3) != 0));
        idle(80, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rvvi_stream_packer.md
RVVI_STREAM_PACKER -- requirements
Module: rvvi_stream_packer

Interface
REQ-001 SHALL have parameter XLEN, default 64: register/PC width in the trace frame.
REQ-002 SHALL have parameter MAX_CSRS, default 5: number of CSR slots in one input frame.
REQ-003 SHALL have parameter OUT_WIDTH, default 64: output beat width in bits; a multiple of 8 and at least 32.
REQ-004 SHALL have parameter DEPTH, default 4: frame FIFO depth; a power of 2, at least 2.
REQ-005 SHALL have parameter FRAME_COUNT_WIDTH, default 16: width of the frame and drop counters.
REQ-006 SHALL define derived constants: BASE=72+5*XLEN; SLOT=XLEN+16; FW=BASE+MAX_CSRS*SLOT.
REQ-007 SHALL have port clk, input, 1 bit: the only clock.
REQ-008 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port InValid, input, 1 bit: frame offered this cycle.
REQ-010 SHALL have port InFrame, input, FW bits: compressed trace frame; base fields in [BASE-1:0], CSR slot k in [BASE+(k+1)*SLOT-1 : BASE+k*SLOT].
REQ-011 SHALL have port InCSRCount, input, $clog2(MAX_CSRS+1) bits: number of populated CSR slots (slots 0..n-1).
REQ-012 SHALL have port InReady, output, 1 bit: FIFO can accept a frame.
REQ-013 SHALL have port OutValid, output, 1 bit: OutData holds a valid beat.
REQ-014 SHALL have port OutReady, input, 1 bit: downstream accepts the beat.
REQ-015 SHALL have port OutData, output, OUT_WIDTH bits: packet beat.
REQ-016 SHALL have port OutLast, output, 1 bit: final beat of a packet.
REQ-017 SHALL have port FrameCount, output, FRAME_COUNT_WIDTH bits: frames accepted, wrapping.
REQ-018 SHALL have port DropCount, output, FRAME_COUNT_WIDTH bits: frames dropped, saturating.
REQ-019 SHALL have port Overflow, output, 1 bit: sticky flag, set when any frame is dropped.

Function
REQ-020 SHALL accept a frame when InValid & InReady are both high; InFrame and InCSRCount are written to the FIFO tail at that clock edge.
REQ-021 SHALL drive InReady = ~Full from registered state only; a pop in the same cycle SHALL NOT free space for a push in that cycle.
REQ-022 SHALL drop a frame offered while Full (InValid & ~InReady): DropCount increments unless it is all-ones, and Overflow sets.
REQ-023 SHALL compute packet payload length L = BASE + n*SLOT bits, with n = InCSRCount clamped to MAX_CSRS; beats B = ceil(L/OUT_WIDTH).
REQ-024 SHALL emit the payload LSB-first, one OUT_WIDTH slice per beat, with bits at or above L zeroed in the final beat.
REQ-025 SHALL run a serializer FSM with states IDLE, SEND and (macro only) HDR.
  - IDLE->SEND, or IDLE->HDR with the macro, when the FIFO is non-empty.
  - Advance one beat on OutValid & OutReady.
  - On the last-beat handshake, pop the FIFO; go to SEND/HDR if another frame is queued, otherwise to IDLE.
REQ-026 SHALL have latency such that a frame accepted at edge T drives its first beat, with OutValid high, in the cycle after T when the FIFO was empty and the serializer idle.
REQ-027 SHALL hold OutData/OutLast stable while OutValid & ~OutReady; OutValid SHALL NOT drop until the handshake completes.
REQ-028 SHALL sustain back-to-back packets with no idle cycle between OutLast and the next first beat.
REQ-029 SHALL assert OutLast only on beat B-1 of the packet (or on the header beat never).
REQ-030 SHALL increment FrameCount, wrapping, on each accepted frame, independent of output progress.

Reset
REQ-031 SHALL, when reset is high at an edge, clear FIFO pointers, FSM (to IDLE), beat index, FrameCount, DropCount and Overflow; any packet in flight is aborted.
REQ-032 SHALL hold after reset: OutValid=0, OutLast=0, OutData=0, InReady=1, FrameCount=0, DropCount=0, Overflow=0; frames offered during reset are not accepted.

Configuration
REQ-033 SHALL, with RVVI_PACKER_SEQ_HDR_EN defined, prefix each packet with one header beat.
  - Header beat: [15:0]=FrameCount value at acceptance, [23:16]=n, [31:24]=B, upper bits zero; OutLast=0.
  - Packets are then B+1 beats long.
REQ-034 SHALL, without RVVI_PACKER_SEQ_HDR_EN, omit the HDR state and header logic; packets are exactly B beats.

Verification
(XLEN=64, MAX_CSRS=5, OUT_WIDTH=64, DEPTH=4; BASE=392, SLOT=80)
REQ-035 SHALL cover: one frame with n=0, OutReady=1 -> 7 beats, OutLast on beat 7, first beat in the cycle after acceptance, bits 392..447 zero.
REQ-036 SHALL cover: frames with n=2 then n=5 back-to-back -> 9 beats then 13 beats, no gap, FrameCount=2.
REQ-037 SHALL cover: OutReady=0 while 6 frames are offered -> 4 accepted, InReady=0, DropCount=2, Overflow=1, FrameCount=4.
REQ-038 SHALL cover: OutReady toggling 1,0,0,1 mid-packet -> OutData stable during the stalls, beats ordered, none lost.
REQ-039 SHALL cover: reset asserted on beat 3 of 9 -> next cycle OutValid=0, InReady=1, all counters 0; a following frame is sent from beat 0.
REQ-040 SHALL cover, with macro defined: a frame with n=1 as the 4th accepted frame -> header beat = 0x0000_0000_0801_0003, then 8 payload beats.
